// File: rtl/fetch_unit.sv
// fetch_unit: PC register, single-outstanding instruction fetch and
// instruction register feeding the decoder, with jump/branch redirect.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   imem_req/addr       word fetch request to instruction memory
//   imem_ack/rdata      memory response, accepted only while fetching
//   stall               downstream not ready, held instruction kept
//   jump, branch_taken  redirect for the held instruction (jump wins)
//   branch_imm          sign-extended word offset for taken branches
//   instr, op, instr_pc held instruction, its opcode and fetch address
//   instr_valid         held instruction is meaningful
//   instr_count         instructions consumed since reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [31:0] branch_imm,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] pc;
  logic [31:0] seq;
  logic [31:0] next_pc;
  logic        take;
  logic        consume;

  assign take    = (state == FETCH) && imem_ack;
  assign consume = (state == HOLD) && !stall;

  // Redirect target; jump overrides a simultaneous taken branch.
  always_comb begin
    seq     = instr_pc + 32'd4;
    next_pc = seq;
    unique case (1'b1)
      jump:
        next_pc = {seq[31:28], instr[25:0], 2'b00};
      (!jump && branch_taken):
        next_pc = seq + (branch_imm << 2);
      default:
        next_pc = seq;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = FETCH;
      FETCH:   if (imem_ack) state_n = HOLD;
      HOLD:    if (!stall) state_n = FETCH;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        instr       <= imem_rdata;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end
      if (consume) begin
        instr_valid <= 1'b0;
        instr_count <= instr_count + 32'd1;
        pc          <= next_pc;
      end
    end
  end

  assign imem_req  = (state == FETCH);
  assign imem_addr = {pc[31:2], 2'b00};
  assign op        = instr[31:26];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit,
// tracking PC and consume count with a transaction-level model.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0040;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        jump;
  logic        branch_taken;
  logic [31:0] branch_imm;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic [31:0] instr_count;

  int n_checks;
  int n_fails;
  logic [31:0] exp_pc;
  logic [31:0] exp_count;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .stall(stall),
    .jump(jump),
    .branch_taken(branch_taken),
    .branch_imm(branch_imm),
    .instr(instr),
    .op(op),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_next(
    input logic [31:0] ipc, input logic [31:0] w,
    input logic j, input logic b, input logic [31:0] imm);
    logic [31:0] s;
    s = ipc + 32'd4;
    if (j)
      return (s & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
    if (b)
      return s + imm * 4;
    return s;
  endfunction

  // One instruction: waits, hold with stalls, consume with redirect.
  // Entered and left at a falling edge with the DUT fetching.
  task automatic do_instr(input int waits, input int stalls,
    input logic [31:0] w, input logic j, input logic b,
    input logic [31:0] imm);
    logic [31:0] ipc;
    for (int i = 0; i <= waits; i++) begin
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
        n_fails++;
        $display("FAIL fetch_req: req=%0b addr=%h want req=1 addr=%h",
                 imem_req, imem_addr, exp_pc);
      end
      n_checks++;
      if (instr_valid !== 1'b0) begin
        n_fails++;
        $display("FAIL fetch_valid: got %0b want 0", instr_valid);
      end
      imem_ack     = (i == waits);
      imem_rdata   = (i == waits) ? w : $urandom;
      stall        = 1'($urandom);
      jump         = 1'($urandom);
      branch_taken = 1'($urandom);
      branch_imm   = $urandom;
      @(negedge clk);
    end
    ipc = exp_pc;
    for (int i = 0; i <= stalls; i++) begin
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== w || op !== w[31:26] ||
          instr_pc !== ipc) begin
        n_fails++;
        $display("FAIL hold_instr: v=%0b instr=%h op=%h pc=%h want 1 %h %h %h",
                 instr_valid, instr, op, instr_pc, w, w[31:26], ipc);
      end
      n_checks++;
      if (imem_req !== 1'b0 || instr_count !== exp_count) begin
        n_fails++;
        $display("FAIL hold_state: req=%0b count=%0d want 0 %0d",
                 imem_req, instr_count, exp_count);
      end
      if (i < stalls) begin
        stall        = 1'b1;
        imem_ack     = 1'($urandom);
        imem_rdata   = $urandom;
        jump         = 1'($urandom);
        branch_taken = 1'($urandom);
        branch_imm   = $urandom;
      end else begin
        stall        = 1'b0;
        imem_ack     = 1'b0;
        jump         = j;
        branch_taken = b;
        branch_imm   = imm;
      end
      @(negedge clk);
    end
    jump         = 1'b0;
    branch_taken = 1'b0;
    branch_imm   = '0;
    exp_count    = exp_count + 32'd1;
    exp_pc       = model_next(ipc, w, j, b, imm);
    n_checks++;
    if (instr_count !== exp_count || instr_valid !== 1'b0 ||
        imem_req !== 1'b1 || imem_addr !== exp_pc) begin
      n_fails++;
      $display("FAIL consume: count=%0d v=%0b req=%0b addr=%h want %0d 0 1 %h",
               instr_count, instr_valid, imem_req, imem_addr,
               exp_count, exp_pc);
    end
  endtask

  // Taken branch straight to an arbitrary word address.
  task automatic branch_to(input logic [31:0] tgt);
    logic [31:0] d;
    d = tgt - (exp_pc + 32'd4);
    do_instr(0, 0, 32'h1000_0000, 1'b0, 1'b1, d >> 2);
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    imem_ack     = 1'b0;
    imem_rdata   = '0;
    stall        = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    branch_imm   = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== RPC || instr !== 32'h0 ||
        op !== 6'h0 || instr_pc !== 32'h0 || instr_valid !== 1'b0 ||
        instr_count !== 32'h0) begin
      n_fails++;
      $display("FAIL reset_vals: req=%0b addr=%h instr=%h op=%h pc=%h v=%0b cnt=%0d",
               imem_req, imem_addr, instr, op, instr_pc, instr_valid,
               instr_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    exp_pc    = RPC;
    exp_count = '0;
  endtask

  task automatic test_start();
    do_instr(0, 0, 32'h2008_0005, 1'b0, 1'b0, '0);
    n_checks++;
    if (instr_count !== 32'd1 || imem_addr !== 32'h44) begin
      n_fails++;
      $display("FAIL start_first: count=%0d addr=%h want 1 00000044",
               instr_count, imem_addr);
    end
    do_instr(0, 0, 32'h2008_0005, 1'b0, 1'b0, '0);
    n_checks++;
    if (imem_addr !== 32'h48) begin
      n_fails++;
      $display("FAIL start_third: addr=%h want 00000048", imem_addr);
    end
  endtask

  task automatic test_wait_states();
    do_instr(3, 0, 32'h8C22_0010, 1'b0, 1'b0, '0);
  endtask

  task automatic test_stall();
    do_instr(0, 5, 32'hAC43_0008, 1'b0, 1'b0, '0);
  endtask

  task automatic test_branch();
    do_instr(0, 0, 32'h0800_0040, 1'b1, 1'b0, '0);
    do_instr(0, 0, 32'h1000_FFFE, 1'b0, 1'b1, 32'hFFFF_FFFE);
    n_checks++;
    if (imem_addr !== 32'h0000_00FC) begin
      n_fails++;
      $display("FAIL branch_back: addr=%h want 000000fc", imem_addr);
    end
    do_instr(0, 0, 32'h0800_0040, 1'b1, 1'b0, '0);
    do_instr(1, 0, 32'h1000_0003, 1'b0, 1'b1, 32'h0000_0003);
    n_checks++;
    if (imem_addr !== 32'h0000_0110) begin
      n_fails++;
      $display("FAIL branch_fwd: addr=%h want 00000110", imem_addr);
    end
  endtask

  task automatic test_jump_priority();
    branch_to(32'h3000_0010);
    do_instr(0, 1, 32'h0800_0004, 1'b1, 1'b1, 32'h0000_0100);
    n_checks++;
    if (imem_addr !== 32'h3000_0010) begin
      n_fails++;
      $display("FAIL jump_prio: addr=%h want 30000010", imem_addr);
    end
  endtask

  task automatic test_wrap();
    branch_to(32'hFFFF_FFFC);
    do_instr(0, 0, 32'h0000_0020, 1'b0, 1'b0, '0);
    n_checks++;
    if (imem_addr !== 32'h0000_0000) begin
      n_fails++;
      $display("FAIL pc_wrap: addr=%h want 00000000", imem_addr);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      logic [31:0] w;
      logic [31:0] imm;
      w   = $urandom;
      imm = {{16{w[15]}}, w[15:0]};
      do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               w, 1'($urandom), 1'($urandom), imm);
    end
  endtask

  task automatic test_mid_reset();
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEC;
    @(negedge clk);
    rst_n    = 1'b1;
    imem_ack = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || instr_count !== 32'h0 ||
        imem_req !== 1'b0 || imem_addr !== RPC || instr !== 32'h0) begin
      n_fails++;
      $display("FAIL mid_reset: v=%0b cnt=%0d req=%0b addr=%h instr=%h",
               instr_valid, instr_count, imem_req, imem_addr, instr);
    end
    @(negedge clk);
    exp_pc    = RPC;
    exp_count = '0;
    do_instr(2, 1, 32'h2008_0005, 1'b0, 1'b0, '0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_start();
    test_wait_states();
    test_stall();
    test_branch();
    test_jump_priority();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
